// File: rtl/step_pulse_gen_if.sv
// Move-command channel from the motion sequencer to the STEP/DIR generator.
// Latency: none (wires only).
// Backpressure: cmd_ready low means the command is ignored, not queued.
//
// Signals: cmd_valid/cmd_ready handshake, cmd_steps (step count),
// cmd_dir (direction), cmd_period (rise-to-rise period in clk cycles).
interface step_pulse_gen_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 20
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [PER_W-1:0] cmd_period;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse-train generator for the stepper driver pins.
// Latency: first STEP rise 1 edge after acceptance, DIR_SETUP+1 edges if DIR changes.
// Backpressure: cmd_ready = !busy; commands offered while busy are dropped.
//
// Ports: clk, rst (async active-low), cmd_if (slave side of the command
// channel), abort (level, clean stop), step/dir (registered pins),
// busy (move in progress), done (1-cycle end-of-move pulse),
// steps_left (steps not yet issued in the current/last move).
module step_pulse_gen #(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 20,
    parameter int PULSE_W   = 50,
    parameter int DIR_SETUP = 100
) (
    input  logic             clk,
    input  logic             rst,
    step_pulse_gen_if.slave  cmd_if,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        IDLE,
        DIR_WAIT,
        HIGH,
        LOW,
        FIN
    } state_t;

    // Shortest legal period: the LOW phase is never shorter than the pulse.
    localparam logic [PER_W-1:0] MIN_PERIOD = PER_W'(2 * PULSE_W);
    localparam logic [PER_W-1:0] HIGH_LOAD  = PER_W'(PULSE_W - 1);
    localparam logic [PER_W-1:0] LOW_SUB    = PER_W'(PULSE_W + 1);

    state_t           state;
    logic [PER_W-1:0] period_q;
    logic [PER_W-1:0] timer;
    logic             abort_pend;
    logic             accept;
    logic [PER_W-1:0] eff_period;

    assign cmd_if.cmd_ready = !busy;
    assign accept           = cmd_if.cmd_valid && !busy;

    always_comb begin
        eff_period = cmd_if.cmd_period;
        if (cmd_if.cmd_period < MIN_PERIOD) begin
            eff_period = MIN_PERIOD;
        end
    end

    // Timers count down to zero; a phase of N cycles is loaded with N-1.
    // DIR_WAIT is always passed through once after acceptance so STEP is a
    // registered rise one edge later; with no DIR change its count is zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            period_q   <= '0;
            timer      <= '0;
            abort_pend <= 1'b0;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        period_q   <= eff_period;
                        dir        <= cmd_if.cmd_dir;
                        steps_left <= cmd_if.cmd_steps;
                        abort_pend <= 1'b0;
                        if (cmd_if.cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= DIR_WAIT;
                            busy  <= 1'b1;
                            timer <= (cmd_if.cmd_dir != dir) ? PER_W'(DIR_SETUP) : '0;
                        end
                    end
                end

                DIR_WAIT: begin
                    if (abort) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (timer == '0) begin
                        state <= HIGH;
                        step  <= 1'b1;
                        timer <= HIGH_LOAD;
                        if (steps_left != '0) begin
                            steps_left <= steps_left - CNT_W'(1);
                        end
                    end else begin
                        timer <= timer - PER_W'(1);
                    end
                end

                // Abort during the pulse is remembered and honoured only once
                // the full high time has elapsed, so no runt pulse reaches the pin.
                HIGH: begin
                    if (timer == '0) begin
                        step <= 1'b0;
                        if (abort || abort_pend) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= LOW;
                            timer <= period_q - LOW_SUB;
                        end
                    end else begin
                        timer <= timer - PER_W'(1);
                        if (abort) begin
                            abort_pend <= 1'b1;
                        end
                    end
                end

                LOW: begin
                    if (abort) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (timer == '0) begin
                        if (steps_left == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state      <= HIGH;
                            step       <= 1'b1;
                            timer      <= HIGH_LOAD;
                            steps_left <= steps_left - CNT_W'(1);
                        end
                    end else begin
                        timer <= timer - PER_W'(1);
                    end
                end

                FIN: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    timer      <= '0;
                    abort_pend <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    step  <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with PULSE_W=4, DIR_SETUP=8.
// Edge numbers are counted per rising clk edge and sampled 1 time unit later.
module tb_step_pulse_gen;

    localparam int CNT_W     = 16;
    localparam int PER_W     = 20;
    localparam int PULSE_W   = 4;
    localparam int DIR_SETUP = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             abort = 1'b0;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    step_pulse_gen_if #(.CNT_W(CNT_W), .PER_W(PER_W)) cmd_if ();

    step_pulse_gen #(
        .CNT_W    (CNT_W),
        .PER_W    (PER_W),
        .PULSE_W  (PULSE_W),
        .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_if    (cmd_if),
        .abort     (abort),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;
    int rises[$];
    int falls[$];
    int sl_rise[$];
    int dones[$];
    logic step_q = 1'b0;

    // Activity recorder: edge numbers of STEP rises/falls and done pulses.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        if (step && !step_q) begin
            rises.push_back(edge_n);
            sl_rise.push_back(int'(steps_left));
        end
        if (!step && step_q) falls.push_back(edge_n);
        if (done) dones.push_back(edge_n);
        step_q = step;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rises.delete();
        falls.delete();
        sl_rise.delete();
        dones.delete();
    endtask

    task automatic send(input int steps, input logic d, input int per, output int acc);
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = CNT_W'(steps);
        cmd_if.cmd_dir    = d;
        cmd_if.cmd_period = PER_W'(per);
        @(posedge clk);
        #1;
        acc = edge_n;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (dones.size() == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(dones.size() > 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int rise_at(input int i, input int base);
        return (i < rises.size()) ? rises[i] - base : -1;
    endfunction

    function automatic int width_at(input int i);
        return (i < rises.size() && i < falls.size()) ? falls[i] - rises[i] : -1;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int exp_sl [3] = '{2, 1, 0};

        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_period = '0;

        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_step", 32'(step), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
        chk("rst_steps_left", 32'(steps_left), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(cmd_if.cmd_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);

        // 3 steps, no DIR change, period 10
        clear_log();
        send(3, 1'b0, 10, a);
        wait_edge(a + 31);
        chk("t1_done_at_31", 32'(done), 1);
        chk("t1_ready_at_31", 32'(cmd_if.cmd_ready), 0);
        wait_edge(a + 32);
        chk("t1_ready_at_32", 32'(cmd_if.cmd_ready), 1);
        chk("t1_busy_at_32", 32'(busy), 0);
        chk("t1_done_at_32", 32'(done), 0);
        wait_done("t1", 10);
        chk("t1_rise_count", 32'(rises.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_rise%0d", i), 32'(rise_at(i, a)), 32'(1 + 10 * i));
            chk($sformatf("t1_width%0d", i), 32'(width_at(i)), 4);
            chk($sformatf("t1_sl%0d", i),
                32'((i < sl_rise.size()) ? sl_rise[i] : -1), 32'(exp_sl[i]));
        end
        chk("t1_done_count", 32'(dones.size()), 1);
        chk("t1_dir", 32'(dir), 0);

        // 2 steps with DIR change 0 -> 1
        clear_log();
        send(2, 1'b1, 10, a);
        chk("t2_dir_after_accept", 32'(dir), 1);
        chk("t2_step_low_in_setup", 32'(step), 0);
        wait_done("t2", 60);
        chk("t2_rise_count", 32'(rises.size()), 2);
        chk("t2_rise0", 32'(rise_at(0, a)), 9);
        chk("t2_rise1", 32'(rise_at(1, a)), 19);
        chk("t2_done_edge", 32'((dones.size() > 0) ? dones[0] - a : -1), 29);

        // Period 3 saturates to 8
        clear_log();
        send(5, 1'b1, 3, a);
        wait_done("t3", 80);
        chk("t3_rise_count", 32'(rises.size()), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_rise%0d", i), 32'(rise_at(i, a)), 32'(1 + 8 * i));
            chk($sformatf("t3_width%0d", i), 32'(width_at(i)), 4);
        end
        chk("t3_done_edge", 32'((dones.size() > 0) ? dones[0] - a : -1), 41);

        // Zero-step command
        clear_log();
        send(0, 1'b1, 10, a);
        chk("t4_busy", 32'(busy), 0);
        wait_done("t4", 5);
        chk("t4_done_edge", 32'((dones.size() > 0) ? dones[0] - a : -1), 0);
        chk("t4_done_count", 32'(dones.size()), 1);
        chk("t4_rise_count", 32'(rises.size()), 0);
        chk("t4_steps_left", 32'(steps_left), 0);

        // Abort two cycles into the third high phase
        clear_log();
        send(10, 1'b1, 10, a);
        wait_edge(a + 22);
        abort = 1'b1;
        wait_edge(a + 23);
        abort = 1'b0;
        wait_done("t5", 20);
        chk("t5_rise_count", 32'(rises.size()), 3);
        chk("t5_width2", 32'(width_at(2)), 4);
        chk("t5_done_edge", 32'((dones.size() > 0) ? dones[0] - a : -1), 25);
        chk("t5_steps_left", 32'(steps_left), 7);
        chk("t5_busy", 32'(busy), 0);

        // Command offered while busy is ignored
        clear_log();
        send(3, 1'b0, 10, a);
        wait_edge(a + 12);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = CNT_W'(7);
        cmd_if.cmd_dir    = 1'b1;
        cmd_if.cmd_period = PER_W'(20);
        chk("t6_ready_busy", 32'(cmd_if.cmd_ready), 0);
        wait_edge(a + 13);
        cmd_if.cmd_valid = 1'b0;
        chk("t6_dir_held", 32'(dir), 0);
        wait_done("t6", 60);
        chk("t6_rise_count", 32'(rises.size()), 3);
        chk("t6_rise1", 32'(rise_at(1, a)), 19);
        chk("t6_rise2", 32'(rise_at(2, a)), 29);
        chk("t6_done_edge", 32'((dones.size() > 0) ? dones[0] - a : -1), 39);
        chk("t6_steps_left", 32'(steps_left), 0);

        // Reset mid-HIGH, then a normal move
        clear_log();
        send(4, 1'b0, 10, a);
        wait_edge(a + 12);
        chk("t7_step_before_rst", 32'(step), 1);
        rst = 1'b0;
        #1;
        chk("t7_rst_step", 32'(step), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        chk("t7_rst_ready", 32'(cmd_if.cmd_ready), 1);
        chk("t7_rst_steps_left", 32'(steps_left), 0);
        @(negedge clk) rst = 1'b1;
        clear_log();
        send(2, 1'b1, 10, a);
        wait_done("t7", 60);
        chk("t7_rise_count", 32'(rises.size()), 2);
        chk("t7_rise0", 32'(rise_at(0, a)), 9);
        chk("t7_rise1", 32'(rise_at(1, a)), 19);
        chk("t7_done_edge", 32'((dones.size() > 0) ? dones[0] - a : -1), 29);
        chk("t7_dir", 32'(dir), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Generates STEP/DIR pulse trains for the stepper driver.
- Each move command is accepted over a valid/ready handshake. A command carries a step count, a direction and a step period in clk cycles.
- The block is the transmit side of the step interface. Its STEP output is what the board-level edge detectors and tach inputs sample.
- It sits between the motion sequencer and the driver pins.

Parameters:
CNT_W, 16, width of step count and remaining-step counter
PER_W, 20, width of step period field (clk cycles)
PULSE_W, 50, STEP high time in clk cycles (>=1)
DIR_SETUP, 100, clk cycles DIR must be stable before a STEP rise after a DIR change (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  move command valid
cmd_ready  output  1  block can accept a command
cmd_steps  input  CNT_W  number of steps to issue
cmd_dir  input  1  direction for this move
cmd_period  input  PER_W  rise-to-rise STEP period, clk cycles
abort  input  1  level; terminate current move cleanly
step  output  1  STEP pin, registered
dir  output  1  DIR pin, registered
busy  output  1  move in progress
done  output  1  one-cycle pulse at end of move (normal or aborted)
steps_left  output  CNT_W  steps not yet issued in current/last move

Behaviour:
- Reset is asynchronous, active-low, on clk rising edge domain. While rst is 0 or after release:
  - step=0, dir=0, cmd_ready=1, busy=0, done=0, steps_left=0
  - state=IDLE, all timers 0
- Handshake:
  - A command is accepted on a clk edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE and is combinationally !busy.
  - cmd_valid while busy is ignored; no queueing.
- Effective period P = max(cmd_period, 2*PULSE_W), latched at acceptance. Saturation is silent.
- Acceptance edge:
  - Latch P and cmd_dir.
  - steps_left <= cmd_steps.
  - dir <= cmd_dir.
- States:
  - IDLE: wait for acceptance.
    - cmd_steps==0: done=1 next cycle, stay IDLE, busy stays 0, no step.
    - Otherwise, if cmd_dir != current dir, go to DIR_WAIT; else go to HIGH.
  - DIR_WAIT: busy=1, step=0. Count DIR_SETUP cycles, then go to HIGH.
  - HIGH: step=1 for exactly PULSE_W cycles. steps_left decrements by 1 on entry, so it changes on the same edge step rises. Then go to LOW.
  - LOW: step=0 for exactly P-PULSE_W cycles.
    - If steps_left==0: go to FIN.
    - Otherwise go to HIGH.
  - FIN: done=1 for one cycle, busy=0 and cmd_ready=1 on the following cycle, return to IDLE.
- Latency:
  - Without a dir change, step rises on the edge after acceptance.
  - With a dir change, step rises DIR_SETUP+1 edges after acceptance.
- Timing:
  - STEP rise-to-rise = P cycles exactly.
  - The last step is followed by a full LOW phase before done.
- busy=1 in DIR_WAIT, HIGH, LOW, FIN.
- dir changes only on an acceptance edge and is held until the next accepted command.
- abort:
  - Sampled every cycle while busy.
  - In DIR_WAIT or LOW: go to FIN next edge; step stays 0.
  - In HIGH: finish the full PULSE_W high time (no runt pulse), then go to FIN with no LOW phase.
  - steps_left retains the count not issued.
  - abort in IDLE has no effect. abort and acceptance in the same cycle: the command is accepted, then aborted on the next cycle.
- Timers are PER_W wide. PULSE_W and DIR_SETUP must fit in PER_W; a violation is a parameter error, not handled at runtime.
- steps_left counts down and never wraps below 0.
- steps_left holds its final value in IDLE until the next accepted command.
- Reset mid-move: all outputs return to reset values immediately. A partial step high pulse is truncated, which is permitted only on reset.

Test Plan:
- PULSE_W=4, DIR_SETUP=8. Accept steps=3, dir=0, period=10 from reset:
  - step rises at edges +1, +11, +21, each high 4 cycles.
  - steps_left goes 3→2→1→0 on those edges.
  - done pulses at edge +31; cmd_ready=1 at +32.
- dir=0, accept steps=2, dir=1, period=10:
  - dir=1 after acceptance edge.
  - First step rise exactly 9 edges after acceptance; 10-cycle period after that.
- Accept steps=5, period=3 with PULSE_W=4: P saturates to 8; step high 4 cycles, low 4 cycles; 5 pulses.
- Accept steps=0: no step activity, busy stays 0, done=1 for one cycle on the next edge.
- steps=10, period=10; assert abort 2 cycles into the 3rd high phase:
  - The high phase completes its full 4 cycles.
  - done follows, with no further rises.
  - steps_left=7.
- Mid-move checks:
  - Pulse cmd_valid with new data while busy: ignored, train unchanged.
  - Drop rst mid-HIGH: step=0, busy=0, cmd_ready=1 immediately; a new command after release runs normally.
